// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer.
// Walks the camera config ROM from address 0 upward. Each 16-bit entry
// {reg_addr, value} becomes one SCCB register write through the master's
// start/ready handshake. 16'hFFF0 inserts a DELAY_CYCLES pause and 16'hFFFF
// ends the table. The entry at LAST_ADDR is the last one ever read.
// Optional build macro CFG_HOLE_SKIP_EN: a 16'hFFFF entry below LAST_ADDR is
// treated as an unpopulated slot and skipped, so the table ends only after
// LAST_ADDR has been processed.
module ov7670_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter logic [7:0]  LAST_ADDR    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_dout_i,
  output logic        sccb_start_o,
  output logic [7:0]  sccb_addr_o,
  output logic [7:0]  sccb_data_o,
  input  logic        sccb_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CNT_W       = $clog2(DELAY_CYCLES + 1);
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_ACK,
    S_WAIT_SCCB,
    S_DELAY,
    S_ADVANCE,
    S_DONE
  } state_e;

  state_e           state_q,      state_d;
  logic [7:0]       rom_addr_q,   rom_addr_d;
  logic [7:0]       sccb_addr_q,  sccb_addr_d;
  logic [7:0]       sccb_data_q,  sccb_data_d;
  logic             sccb_start_q, sccb_start_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      sccb_addr_q  <= '0;
      sccb_data_q  <= '0;
      sccb_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed in the previous cycle, independent of statement order.
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      sccb_addr_q  <= sccb_addr_d;
      sccb_data_q  <= sccb_data_d;
      sccb_start_q <= sccb_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: ROM walk, entry decode, SCCB handshake and delay timer.
  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    sccb_addr_d  = sccb_addr_q;
    sccb_data_d  = sccb_data_q;
    sccb_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rom_addr_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      // ROM output is registered: one cycle before the entry is valid.
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_dout_i == ENTRY_END) begin
`ifdef CFG_HOLE_SKIP_EN
          state_d = (rom_addr_q == LAST_ADDR) ? S_DONE : S_ADVANCE;
`else
          state_d = S_DONE;
`endif
        end else if (rom_dout_i == ENTRY_DELAY) begin
          cnt_d   = CNT_W'(DELAY_CYCLES - 1);
          state_d = S_DELAY;
        end else begin
          sccb_addr_d = rom_dout_i[15:8];
          sccb_data_d = rom_dout_i[7:0];
          state_d     = S_SEND;
        end
      end
      // Hold addr/data and wait for the master to go idle before requesting.
      S_SEND: begin
        if (sccb_ready_i) begin
          sccb_start_d = 1'b1;
          state_d      = S_ACK;
        end
      end
      // Pulse cycle; ready is still high here from before the request.
      S_ACK: state_d = S_WAIT_SCCB;
      S_WAIT_SCCB: begin
        if (sccb_ready_i) begin
          state_d = S_ADVANCE;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_ADVANCE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ADVANCE: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = rom_addr_q + 8'd1;
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr_o   = rom_addr_q;
  assign sccb_start_o = sccb_start_q;
  assign sccb_addr_o  = sccb_addr_q;
  assign sccb_data_o  = sccb_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Testbench for ov7670_config_sequencer.
// A registered ROM model and an SCCB master model with programmable busy time
// drive the DUT. The expected write list is derived from the ROM contents by
// the table rules; a negedge compare process checks every SCCB request against
// it along with pulse width, handshake and stability rules. Directed tests add
// hand-computed literal expectations.
// Honours CFG_HOLE_SKIP_EN the same way the design does.
module tb_ov7670_config_sequencer;

  localparam int         DELAY = 8;
  localparam logic [7:0] LAST  = 8'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rom_addr_o;
  logic [15:0] rom_dout_i;
  logic        sccb_start_o;
  logic [7:0]  sccb_addr_o;
  logic [7:0]  sccb_data_o;
  logic        sccb_ready_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ov7670_config_sequencer #(
    .DELAY_CYCLES(DELAY),
    .LAST_ADDR   (LAST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .rom_addr_o  (rom_addr_o),
    .rom_dout_i  (rom_dout_i),
    .sccb_start_o(sccb_start_o),
    .sccb_addr_o (sccb_addr_o),
    .sccb_data_o (sccb_data_o),
    .sccb_ready_i(sccb_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Config ROM model: data registered one clock after the address.
  logic [15:0] rom [0:255];
  always @(posedge clk) rom_dout_i <= rom[rom_addr_o];

  // SCCB master model: accepts a request while idle, then stays busy m_lat clk.
  int   m_lat = 1;
  int   m_cnt;
  logic m_block = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             m_cnt <= 0;
    else if (m_cnt > 0)                     m_cnt <= m_cnt - 1;
    else if (sccb_start_o && sccb_ready_i)  m_cnt <= m_lat;
  end
  assign sccb_ready_i = (m_cnt == 0) && !m_block;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: the ordered list of writes a ROM table must produce.
  logic [15:0] exp_q[$];
  task automatic build_model();
    exp_q.delete();
    for (int a = 0; a <= int'(LAST); a++) begin
      if (rom[a] == 16'hFFFF) begin
`ifdef CFG_HOLE_SKIP_EN
        if (a < int'(LAST)) continue;
`endif
        break;
      end
      if (rom[a] == 16'hFFF0) continue;
      exp_q.push_back(rom[a]);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mon_e;
  logic [7:0]  held_a, held_d;
  logic        prev_start = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  logic        outstanding = 1'b0;
  int          last_rise = -1;
  int          pulses = 0;
  int          rise_q[$];

  // Compare process: checks every SCCB request and hold rule against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 1'b0;
      prev_start  = 1'b0;
      prev_busy   = 1'b0;
      prev_done   = 1'b0;
      prev_ready  = sccb_ready_i;
    end else begin
      if (busy_o && !prev_busy) begin
        build_model();
        pulses    = 0;
        last_rise = -1;
        rise_q.delete();
      end
      check("busy_done_exclusive", 32'(busy_o & done_o), 32'd0);
      check("rom_addr_in_range", 32'(rom_addr_o <= LAST), 32'd1);
      if (sccb_start_o) begin
        pulses++;
        check("start_width_1clk", 32'(prev_start), 32'd0);
        check("start_when_ready", 32'(sccb_ready_i), 32'd1);
        if (last_rise >= 0) check("pulse_after_rise_plus4", 32'((cyc - last_rise) >= 4), 32'd1);
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("sccb_addr", 32'(sccb_addr_o), 32'(mon_e[15:8]));
          check("sccb_data", 32'(sccb_data_o), 32'(mon_e[7:0]));
        end
        outstanding = 1'b1;
        held_a = sccb_addr_o;
        held_d = sccb_data_o;
      end else if (outstanding) begin
        check("sccb_addr_stable", 32'(sccb_addr_o), 32'(held_a));
        check("sccb_data_stable", 32'(sccb_data_o), 32'(held_d));
        if (sccb_ready_i && !prev_ready) begin
          outstanding = 1'b0;
          last_rise   = cyc;
          rise_q.push_back(cyc);
        end
      end
      if (done_o && !prev_done) check("all_writes_issued", 32'(exp_q.size()), 32'd0);
      prev_start = sccb_start_o;
      prev_busy  = busy_o;
      prev_done  = done_o;
      prev_ready = sccb_ready_i;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_within_budget", 32'(done_o), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"},   32'(rom_addr_o),   32'd0);
    check({tag, "_sccb_start"}, 32'(sccb_start_o), 32'd0);
    check({tag, "_sccb_addr"},  32'(sccb_addr_o),  32'd0);
    check({tag, "_sccb_data"},  32'(sccb_data_o),  32'd0);
    check({tag, "_busy"},       32'(busy_o),       32'd0);
    check({tag, "_done"},       32'(done_o),       32'd0);
  endtask

  task automatic reset_and_watch(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals(tag);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check({tag, "_no_start_after_reset"}, 32'(sccb_start_o), 32'd0);
    end
    check({tag, "_busy_stays_low"}, 32'(busy_o), 32'd0);
    check({tag, "_done_stays_low"}, 32'(done_o), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  int gap;

  // Directed stimulus.
  initial begin
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;

    // Write, delay entry, write, end marker with an instant-ack master.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1210; rom[3] = 16'hFFFF;
    m_lat = 1;
    pulse_start();
    check("a_busy_after_start", 32'(busy_o), 32'd1);
    check("a_addr_after_start", 32'(rom_addr_o), 32'd0);
    for (int i = 0; i < 200 && rom_addr_o != 8'd2; i++) @(negedge clk);
    check("a_reached_addr2", 32'(rom_addr_o), 32'd2);
    check("a_first_write_done", 32'(rise_q.size() >= 1), 32'd1);
    if (rise_q.size() >= 1) begin
      gap = cyc - rise_q[0];
      // completion, ADVANCE, FETCH, DECODE, DELAY x8, ADVANCE, then addr 2
      check("a_delay_gap_model", 32'(gap), 32'(DELAY + 5));
      check("a_delay_gap_literal", 32'(gap), 32'd13);
    end
    wait_done(300);
    check("a_pulses", 32'(pulses), 32'd2);
    check("a_busy_low_at_done", 32'(busy_o), 32'd0);

    // Restart from done; start held high for the whole run, including DONE.
    pulse_start();
    check("d_done_cleared", 32'(done_o), 32'd0);
    check("d_restart_addr0", 32'(rom_addr_o), 32'd0);
    check("d_busy_restart", 32'(busy_o), 32'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) break;
      start_i = busy_o;
    end
    start_i = 1'b0;
    check("d_done_set", 32'(done_o), 32'd1);
    repeat (5) @(negedge clk);
    check("d_no_restart_done", 32'(done_o), 32'd1);
    check("d_no_restart_busy", 32'(busy_o), 32'd0);
    check("d_pulses", 32'(pulses), 32'd2);

    // Master busy elsewhere for 50 clk before the first write.
    m_block = 1'b1;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("b_no_start_while_busy", 32'(sccb_start_o), 32'd0);
      if (i >= 2) begin
        check("b_addr_held", 32'(sccb_addr_o), 32'h12);
        check("b_data_held", 32'(sccb_data_o), 32'h80);
      end
    end
    m_block = 1'b0;
    wait_done(300);
    check("b_pulses", 32'(pulses), 32'd2);

    // Slow master: 100 clk per write.
    m_lat = 100;
    pulse_start();
    wait_done(1000);
    check("c_pulses", 32'(pulses), 32'd2);
    check("c_write_completions", 32'(rise_q.size()), 32'd2);

    // Reset while in the delay entry.
    m_lat = 1;
    pulse_start();
    for (int i = 0; i < 100 && rom_addr_o != 8'd1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    reset_and_watch("e_delay");

    // Reset while waiting for the SCCB master.
    m_lat = 100;
    pulse_start();
    for (int i = 0; i < 100 && !sccb_start_o; i++) @(negedge clk);
    check("e_saw_first_start", 32'(sccb_start_o), 32'd1);
    repeat (10) @(negedge clk);
    reset_and_watch("e_wait");

    // No terminator: the entry at LAST_ADDR is the last one; FFxx are writes.
    clear_rom();
    rom[0] = 16'h0A01; rom[1] = 16'hFF12; rom[2] = 16'hFFFE;
    rom[3] = 16'h0B03; rom[4] = 16'hFFF0; rom[5] = 16'h0C05; rom[6] = 16'h0D06;
    m_lat = 1;
    pulse_start();
    wait_done(500);
    check("f_pulses", 32'(pulses), 32'd5);
    check("f_final_addr", 32'(rom_addr_o), 32'd5);

    // Unpopulated slot in the middle of the table.
    clear_rom();
    rom[0] = 16'h1101; rom[2] = 16'h0C04; rom[6] = 16'h0D06;
    pulse_start();
    wait_done(500);
`ifdef CFG_HOLE_SKIP_EN
    check("g_pulses", 32'(pulses), 32'd2);
    check("g_final_addr", 32'(rom_addr_o), 32'd5);
`else
    check("g_pulses", 32'(pulses), 32'd1);
    check("g_final_addr", 32'(rom_addr_o), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
